// File: rtl/cic_up125.sv
// cic_up125: three-stage CIC interpolator with a fixed upsampling factor R.
// A comb section running at the input rate feeds a zero-stuffed integrator
// cascade that runs at the output rate. Both sides use valid/ready handshakes
// with packet and error sidebands. The integrator cascade only advances when
// the output register is free or is being drained, so backpressure freezes it.
module cic_up125 #(
    parameter int R          = 125,
    parameter int IN_W       = 16,
    parameter int GAIN_SHIFT = 14
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_startofpacket,
    input  logic            in_endofpacket,
    input  logic [1:0]      in_error,
    output logic [IN_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_startofpacket,
    output logic            out_endofpacket,
    output logic [1:0]      out_error,
    output logic            out_channel
);
    localparam int W    = IN_W + GAIN_SHIFT;
    localparam int PH_W = $clog2(R);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

    // Sign-extend an input sample to the full datapath width.
    function automatic logic [W-1:0] sext_in(input logic [IN_W-1:0] v);
        return {{GAIN_SHIFT{v[IN_W-1]}}, v};
    endfunction

    // Comb section state (input rate)
    logic [W-1:0]    r_d1, r_d2, r_d3, r_cval;
    logic            r_sop, r_eop;
    logic [1:0]      r_err;

    // Sequencing state
    logic            r_busy;
    logic [PH_W-1:0] r_phase;

    // Integrator section state (output rate)
    logic [W-1:0]    r_i1, r_i2, r_i3;

    // Output registers
    logic [IN_W-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_out_sop, r_out_eop;
    logic [1:0]      r_out_err;

    // Combinational nets
    logic [W-1:0]    w_x, w_c1, w_c2, w_c3;
    logic [W-1:0]    w_u, w_i1n, w_i2n, w_i3n;
    logic            w_step, w_last, w_first, w_in_ready, w_acc;

    // Datapath and handshake decode: comb cascade, zero-stuffing, integrator cascade.
    always_comb begin
        w_x        = sext_in(in_data);
        w_c1       = w_x  - r_d1;
        w_c2       = w_c1 - r_d2;
        w_c3       = w_c2 - r_d3;
        w_first    = (r_phase == {PH_W{1'b0}});
        w_last     = (r_phase == PH_LAST);
        w_step     = r_busy & (~r_out_valid | out_ready);
        w_in_ready = ~r_busy | (w_step & w_last);
        w_acc      = in_valid & w_in_ready;
        w_u        = {W{1'b0}};
        if (w_first) begin
            w_u = r_cval;
        end else begin
            w_u = {W{1'b0}};
        end
        w_i1n = r_i1 + w_u;
        w_i2n = r_i2 + w_i1n;
        w_i3n = r_i3 + w_i2n;
    end

    // Comb delay line and sideband capture, updated once per accepted input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1   <= {W{1'b0}};
            r_d2   <= {W{1'b0}};
            r_d3   <= {W{1'b0}};
            r_cval <= {W{1'b0}};
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_err  <= 2'b00;
        end else if (w_acc) begin
            r_d1   <= w_x;
            r_d2   <= w_c1;
            r_d3   <= w_c2;
            r_cval <= w_c3;
            r_sop  <= in_startofpacket;
            r_eop  <= in_endofpacket;
            r_err  <= in_error;
        end
    end

    // Phase counter: a new input restarts at phase 0 and wins over the final step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_phase <= {PH_W{1'b0}};
        end else if (w_acc) begin
            r_busy  <= 1'b1;
            r_phase <= {PH_W{1'b0}};
        end else if (w_step) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

    // Integrators and output register: advance on a step, drop valid once drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i1        <= {W{1'b0}};
            r_i2        <= {W{1'b0}};
            r_i3        <= {W{1'b0}};
            r_out_data  <= {IN_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_err   <= 2'b00;
        end else if (w_step) begin
            r_i1        <= w_i1n;
            r_i2        <= w_i2n;
            r_i3        <= w_i3n;
            r_out_data  <= w_i3n[W-1:GAIN_SHIFT];
            r_out_valid <= 1'b1;
            r_out_sop   <= r_sop & w_first;
            r_out_eop   <= r_eop & w_last;
            r_out_err   <= r_err;
        end else if (r_out_valid & out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready          = w_in_ready;
    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_error         = r_out_err;
    assign out_channel       = 1'b0;

endmodule

// File: tb/tb_cic_up125.sv
// tb_cic_up125: directed/randomized bench for cic_up125. The reference model
// computes each output as the closed-form sum of third-difference comb values
// weighted by the triangular-number impulse response of three cascaded
// accumulators, evaluated modulo 2^30.
module tb_cic_up125;
    localparam int R = 125;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_error;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_error;
    logic        out_channel;

    cic_up125 dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_error          (in_error),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_error         (out_error),
        .out_channel       (out_channel)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Source queue (samples waiting to be offered)
    logic [15:0] src_d[$];
    logic        src_sop[$];
    logic        src_eop[$];
    logic [1:0]  src_err[$];

    // Model: accepted inputs since reset, produced/consumed output counts
    int          m_x[$];
    logic        m_sop[$];
    logic        m_eop[$];
    logic [1:0]  m_err[$];
    int          p;
    int          k;
    bit          m_ov;

    // Observation records
    logic [15:0] obs_seq[$];
    logic [15:0] step_seq[$];
    int          acc_cyc[$];
    int          cyc, out_first, out_last;
    int          sop_cnt, sop_idx, eop_cnt, eop_idx, err_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x.delete(); m_sop.delete(); m_eop.delete(); m_err.delete();
        src_d.delete(); src_sop.delete(); src_eop.delete(); src_err.delete();
        obs_seq.delete(); acc_cyc.delete();
        p = 0; k = 0; m_ov = 1'b0;
        out_first = -1; out_last = -1;
        sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1; err_ok = 0;
    endtask

    task automatic push_src(input logic [15:0] d, input logic s, input logic e, input logic [1:0] r);
        src_d.push_back(d); src_sop.push_back(s); src_eop.push_back(e); src_err.push_back(r);
    endtask

    function automatic longint xh(input int i);
        if (i < 0) return 64'sd0;
        return longint'(m_x[i]);
    endfunction

    // Expected output number kk since reset.
    task automatic expect_out(input int kk, output logic [15:0] yd, output logic ys,
                              output logic ye, output logic [1:0] yr);
        longint s;
        longint c;
        longint mm;
        logic [63:0] sv;
        int nc;
        int mk;
        s  = 0;
        nc = kk / R;
        mk = kk % R;
        for (int n = 0; n <= nc; n++) begin
            c  = xh(n) - 3 * xh(n - 1) + 3 * xh(n - 2) - xh(n - 3);
            mm = longint'(kk - n * R);
            s  = s + c * (((mm + 1) * (mm + 2)) / 2);
        end
        sv = s;
        yd = sv[29:14];
        ys = m_sop[nc] & (mk == 0);
        ye = m_eop[nc] & (mk == R - 1);
        yr = m_err[nc];
    endtask

    // One clock: drive at negedge, check, update model, advance to next negedge.
    task automatic one_cycle(input bit rdy_rand, input bit val_rand);
        bit          busy, stp, lst;
        logic        exp_ir;
        logic [15:0] yd;
        logic        ys, ye;
        logic [1:0]  yr;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (src_d.size() > 0 && (!val_rand || $urandom_range(0, 2) != 0)) begin
            in_valid         = 1'b1;
            in_data          = src_d[0];
            in_startofpacket = src_sop[0];
            in_endofpacket   = src_eop[0];
            in_error         = src_err[0];
        end else begin
            in_valid         = 1'b0;
            in_data          = 16'($urandom);
            in_startofpacket = 1'($urandom);
            in_endofpacket   = 1'($urandom);
            in_error         = 2'($urandom);
        end
        #1;
        busy   = (p < R * m_x.size());
        stp    = busy && (!m_ov || out_ready);
        lst    = ((p % R) == R - 1);
        exp_ir = !busy || (stp && lst);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov && out_ready) begin
            expect_out(k, yd, ys, ye, yr);
            chk("out_data", {16'd0, out_data}, {16'd0, yd});
            chk("out_sop", {31'd0, out_startofpacket}, {31'd0, ys});
            chk("out_eop", {31'd0, out_endofpacket}, {31'd0, ye});
            chk("out_err", {30'd0, out_error}, {30'd0, yr});
            obs_seq.push_back(out_data);
            if (out_first < 0) out_first = cyc;
            out_last = cyc;
            if (out_startofpacket === 1'b1) begin sop_cnt++; sop_idx = k; end
            if (out_endofpacket === 1'b1) begin eop_cnt++; eop_idx = k; end
            if (out_error === 2'b10) err_ok++;
            k++;
        end
        if (stp) begin
            p++;
            m_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (in_valid && exp_ir) begin
            m_x.push_back(int'($signed(src_d[0])));
            m_sop.push_back(src_sop[0]);
            m_eop.push_back(src_eop[0]);
            m_err.push_back(src_err[0]);
            void'(src_d.pop_front()); void'(src_sop.pop_front());
            void'(src_eop.pop_front()); void'(src_err.pop_front());
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_drained(input bit rdy_rand, input bit val_rand, input int budget);
        int c;
        c = 0;
        while ((src_d.size() > 0 || p < R * m_x.size() || m_ov) && c < budget) begin
            one_cycle(rdy_rand, val_rand);
            c++;
        end
        chk("drain_budget", {31'd0, (c < budget)}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; in_startofpacket = 1'b0;
        in_endofpacket = 1'b0; in_error = 2'b00; out_ready = 1'b0; cyc = 0;
        model_reset();
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_sop", {31'd0, out_startofpacket}, 32'd0);
        chk("rst_out_eop", {31'd0, out_endofpacket}, 32'd0);
        chk("rst_out_err", {30'd0, out_error}, 32'd0);
        chk("rst_out_channel", {31'd0, out_channel}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Step response: DC 16384, sink always ready
        for (int i = 0; i < 4; i++) push_src(16'd16384, 1'b0, 1'b0, 2'b00);
        run_until_drained(1'b0, 1'b0, 2000);
        chk("step_count", obs_seq.size(), 32'd500);
        for (int i = 0; i < 4; i++) chk("step_tri", {16'd0, obs_seq[i]}, ((i + 1) * (i + 2)) / 2);
        chk("step_settle375", {16'd0, obs_seq[375]}, 32'd15625);
        chk("step_settle499", {16'd0, obs_seq[499]}, 32'd15625);
        step_seq = obs_seq;

        // Full throughput: constant -20000
        do_reset();
        for (int i = 0; i < 4; i++) push_src(16'(-20000), 1'b0, 1'b0, 2'b00);
        run_until_drained(1'b0, 1'b0, 2000);
        chk("thru_count", obs_seq.size(), 32'd500);
        chk("thru_no_gap", out_last - out_first, 32'd499);
        chk("thru_accepts", acc_cyc.size(), 32'd4);
        for (int i = 1; i < 4; i++) chk("thru_period", acc_cyc[i] - acc_cyc[i - 1], 32'd125);

        // Backpressure: random sink stalls and source gaps, same DC input
        do_reset();
        for (int i = 0; i < 4; i++) push_src(16'd16384, 1'b0, 1'b0, 2'b00);
        run_until_drained(1'b1, 1'b1, 6000);
        chk("bp_count", obs_seq.size(), 32'd500);
        for (int i = 0; i < 500; i++) chk("bp_seq", {16'd0, obs_seq[i]}, {16'd0, step_seq[i]});

        // Packet sidebands
        do_reset();
        push_src(16'($urandom), 1'b1, 1'b0, 2'b10);
        push_src(16'($urandom), 1'b0, 1'b1, 2'b10);
        run_until_drained(1'b1, 1'b0, 4000);
        chk("pkt_sop_cnt", sop_cnt, 32'd1);
        chk("pkt_sop_idx", sop_idx, 32'd0);
        chk("pkt_eop_cnt", eop_cnt, 32'd1);
        chk("pkt_eop_idx", eop_idx, 32'd249);
        chk("pkt_err_cnt", err_ok, 32'd250);

        // Wrap-around: alternating full-scale inputs
        do_reset();
        for (int i = 0; i < 8; i++) push_src((i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b0, 1'b0, 2'b00);
        run_until_drained(1'b0, 1'b0, 2000);
        chk("wrap_count", obs_seq.size(), 32'd1000);

        // Idle with integrators holding, then random traffic continuing the stream
        for (int i = 0; i < 20; i++) one_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push_src(16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        run_until_drained(1'b1, 1'b1, 4000);
        chk("idle_resume_count", obs_seq.size(), 32'd1375);

        // Mid-stream reset
        do_reset();
        for (int i = 0; i < 4; i++) push_src(16'($urandom), 1'b0, 1'b0, 2'($urandom));
        for (int i = 0; i < 300; i++) one_cycle(1'b1, 1'b1);
        in_valid = 1'b1;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_out_sop", {31'd0, out_startofpacket}, 32'd0);
        chk("mid_rst_out_err", {30'd0, out_error}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        push_src(16'($urandom), 1'b1, 1'b1, 2'b01);
        run_until_drained(1'b1, 1'b0, 3000);
        chk("post_rst_count", obs_seq.size(), 32'd125);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
